bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of WAIT cycles before a transaction is aborted.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports a_addr_i / a_wdata_i, input, 16 bits each: requester A transaction address and write data.
REQ-005 SHALL have ports a_rw_i and a_valid_i, input, 1 bit each: requester A direction (1 = write) and request strobe.
REQ-006 SHALL have port a_ready_o, output, 1 bit: requester A request accepted this cycle.
REQ-007 SHALL have port a_rdata_o, output, 16 bits: requester A response data.
REQ-008 SHALL have ports a_done_o and a_err_o, output, 1 bit each: requester A completion and timeout pulses.
REQ-009 SHALL have ports b_* for requester B, identical to REQ-004..REQ-008.
REQ-010 SHALL have ports addr_o / wdata_o / rdata_o, output, 16 bits each: core-chain head.
REQ-011 SHALL have ports rw_o / valid_o, output, 1 bit each: core-chain head.
REQ-012 SHALL have ports addr_i / rdata_i, input, 16 bits each: core-chain tail return.
REQ-013 SHALL have ports rw_i / valid_i, input, 1 bit each: core-chain tail return.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with one transaction outstanding at most.
REQ-015 In IDLE, SHALL assert x_ready_o combinationally for exactly one requester with x_valid_i high.
REQ-016 Handshake completes when valid and ready are both high; SHALL latch addr, wdata and rw and enter ISSUE.
REQ-017 When both requesters are valid, SHALL grant round-robin: the requester not granted last wins; after reset, A wins first.
REQ-018 SHALL hold ready low for both requesters in ISSUE, WAIT and RESP.
REQ-019 In ISSUE, SHALL drive valid_o = 1 for exactly one cycle with latched addr_o, wdata_o and rw_o, and rdata_o = 0, then enter WAIT.
REQ-020 Outside ISSUE, SHALL drive valid_o = 0 and hold the other chain outputs at their last values.
REQ-021 In WAIT, SHALL match a return when valid_i = 1, addr_i equals the latched addr, and rw_i equals the latched rw; non-matching returns are ignored.
REQ-022 On a match, SHALL latch rdata_i (reads) or 0 (writes) and enter RESP.
REQ-023 In RESP, SHALL pulse x_done_o for one cycle to the granted requester, with x_rdata_o valid in that cycle, then return to IDLE.
REQ-024 x_rdata_o SHALL hold its value until the next done for that requester.
REQ-025 WAIT cycle counter: 8-bit minimum, cleared on WAIT entry.
REQ-026 When the counter reaches TIMEOUT without a match, SHALL pulse x_err_o and x_done_o in the same cycle, set x_rdata_o = 0, and go to IDLE.
REQ-027 A match in the same cycle as timeout SHALL take priority; no err is raised.
REQ-028 Minimum latency from accept to done SHALL be 3 cycles plus chain latency.
REQ-029 SHALL never issue a new request in the same cycle as a done.

Reset
REQ-030 While rst_n = 0: state IDLE, all outputs 0, counter 0, round-robin pointer set to favour A.
REQ-031 Reset mid-transaction SHALL abort it with no done or err pulse.
REQ-032 Chain returns arriving after reset SHALL be ignored.

Verification
REQ-033 A reads 0x0002 with a 2-cycle loopback returning rdata 0x03FF -> valid_o one cycle with addr_o = 0x0002, rw_o = 0; a_done_o pulses with a_rdata_o = 0x03FF; b outputs stay 0.
REQ-034 A and B both valid in IDLE after reset -> A granted first, B accepted in the first IDLE cycle after A's done, then A granted again when both are valid.
REQ-035 B writes 0x0005 with data 0x001F -> valid_o = 1, rw_o = 1, wdata_o = 0x001F; b_done_o pulses, b_rdata_o = 0, b_err_o = 0.
REQ-036 Chain never returns, TIMEOUT = 4 -> err and done pulse together 4 WAIT cycles after issue; rdata = 0; arbiter back in IDLE.
REQ-037 Return with addr_i = 0x0003 while 0x0002 is outstanding -> ignored; the later 0x0002 return completes normally.
REQ-038 rst_n low during WAIT, then the late chain return arrives -> no done/err; next request from A serviced normally.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter driving a single-outstanding core chain.
// One request is issued per transaction; returns are matched on addr/rw and a WAIT timeout aborts.
`timescale 1ns/1ps
module bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a_addr_i,
  input  logic [15:0] a_wdata_i,
  input  logic        a_rw_i,
  input  logic        a_valid_i,
  output logic        a_ready_o,
  output logic [15:0] a_rdata_o,
  output logic        a_done_o,
  output logic        a_err_o,
  input  logic [15:0] b_addr_i,
  input  logic [15:0] b_wdata_i,
  input  logic        b_rw_i,
  input  logic        b_valid_i,
  output logic        b_ready_o,
  output logic [15:0] b_rdata_o,
  output logic        b_done_o,
  output logic        b_err_o,
  output logic [15:0] addr_o,
  output logic [15:0] wdata_o,
  output logic [15:0] rdata_o,
  output logic        rw_o,
  output logic        valid_o,
  input  logic [15:0] addr_i,
  input  logic [15:0] rdata_i,
  input  logic        rw_i,
  input  logic        valid_i
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic            prio_b_q, prio_b_d;
  logic            gnt_b_q, gnt_b_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            rw_q, rw_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     a_rdata_q, a_rdata_d;
  logic [15:0]     b_rdata_q, b_rdata_d;
  logic            a_done_q, a_done_d;
  logic            b_done_q, b_done_d;
  logic            a_err_q, a_err_d;
  logic            b_err_q, b_err_d;

  logic            grant_b;
  logic            match;
  logic [CW-1:0]   cnt_inc;
  logic [15:0]     resp_data;

  // B wins only when A is idle or B holds the round-robin priority
  assign grant_b   = b_valid_i && (!a_valid_i || prio_b_q);
  assign a_ready_o = rst_n && (state_q == IDLE) && a_valid_i && !grant_b;
  assign b_ready_o = rst_n && (state_q == IDLE) && grant_b;
  assign match     = valid_i && (addr_i == addr_q) && (rw_i == rw_q);
  assign cnt_inc   = cnt_q + CW'(1);
  assign resp_data = rw_q ? 16'h0000 : rdata_i;

  assign valid_o   = (state_q == ISSUE);
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign rw_o      = rw_q;
  assign rdata_o   = 16'h0000;
  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;
  assign a_done_o  = a_done_q;
  assign b_done_o  = b_done_q;
  assign a_err_o   = a_err_q;
  assign b_err_o   = b_err_q;

  always_comb begin
    state_d   = state_q;
    prio_b_d  = prio_b_q;
    gnt_b_d   = gnt_b_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    cnt_d     = cnt_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    a_done_d  = 1'b0;
    b_done_d  = 1'b0;
    a_err_d   = 1'b0;
    b_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_ready_o || b_ready_o) begin
          addr_d   = grant_b ? b_addr_i  : a_addr_i;
          wdata_d  = grant_b ? b_wdata_i : a_wdata_i;
          rw_d     = grant_b ? b_rw_i    : a_rw_i;
          gnt_b_d  = grant_b;
          prio_b_d = !grant_b;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A return landing on the timeout cycle still completes normally
        if (match) begin
          if (gnt_b_q) begin
            b_rdata_d = resp_data;
            b_done_d  = 1'b1;
          end else begin
            a_rdata_d = resp_data;
            a_done_d  = 1'b1;
          end
          state_d = RESP;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          if (gnt_b_q) begin
            b_rdata_d = 16'h0000;
            b_done_d  = 1'b1;
            b_err_d   = 1'b1;
          end else begin
            a_rdata_d = 16'h0000;
            a_done_d  = 1'b1;
            a_err_d   = 1'b1;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prio_b_q  <= 1'b0;
      gnt_b_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      cnt_q     <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_b_q  <= prio_b_d;
      gnt_b_q   <= gnt_b_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      cnt_q     <= cnt_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      a_err_q   <= a_err_d;
      b_err_q   <= b_err_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: vector table plus arbitration and reset sequences, scoreboarded on done.
`timescale 1ns/1ps
module tb_bus_arbiter;

  localparam int TO        = 4;
  localparam int M_GOOD    = 0;
  localparam int M_NONE    = 1;
  localparam int M_BADADDR = 2;
  localparam int M_BADRW   = 3;
  localparam int NV        = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a_addr_i, a_wdata_i, b_addr_i, b_wdata_i;
  logic        a_rw_i, a_valid_i, b_rw_i, b_valid_i;
  logic        a_ready_o, a_done_o, a_err_o, b_ready_o, b_done_o, b_err_o;
  logic [15:0] a_rdata_o, b_rdata_o;
  logic [15:0] addr_o, wdata_o, rdata_o;
  logic        rw_o, valid_o;
  logic [15:0] addr_i, rdata_i;
  logic        rw_i, valid_i;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i), .a_rw_i(a_rw_i), .a_valid_i(a_valid_i),
    .a_ready_o(a_ready_o), .a_rdata_o(a_rdata_o), .a_done_o(a_done_o), .a_err_o(a_err_o),
    .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i), .b_rw_i(b_rw_i), .b_valid_i(b_valid_i),
    .b_ready_o(b_ready_o), .b_rdata_o(b_rdata_o), .b_done_o(b_done_o), .b_err_o(b_err_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o), .rw_o(rw_o), .valid_o(valid_o),
    .addr_i(addr_i), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i)
  );

  typedef struct {
    logic        who;
    logic [15:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rw;
  } iss_t;

  typedef struct {
    logic        who;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rw;
    logic [15:0] ret;
    int          lat;
    int          mode;
    logic [15:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  exp_t        exp_q[$];
  iss_t        iss_q[$];
  int          tests = 0;
  int          failed = 0;
  int          cyc = 0;
  int          iss_cyc = 0;
  int          done_cnt = 0;
  int          acc_cyc[2];
  int          done_cyc[2];
  logic [15:0] last_rd[2];
  logic        valid_prev = 1'b0;
  int          chain_mode = M_GOOD;
  int          chain_lat = 1;
  logic [15:0] chain_ret = 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; holds valid until accepted, then pushes the expected outcome.
  task automatic req(input logic who, input logic [15:0] addr, input logic [15:0] wdata,
                     input logic rw, input logic [15:0] exp_rd, input logic exp_err,
                     input int exp_lat);
    int n;
    n = 0;
    if (who) begin
      b_addr_i = addr; b_wdata_i = wdata; b_rw_i = rw; b_valid_i = 1'b1;
    end else begin
      a_addr_i = addr; a_wdata_i = wdata; a_rw_i = rw; a_valid_i = 1'b1;
    end
    #1;
    while (!(who ? b_ready_o : a_ready_o) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!(who ? b_ready_o : a_ready_o)) begin
      tests++;
      failed++;
      $display("FAIL accept_timeout who=%0d: ready stayed 0, required 1", who);
    end else begin
      exp_q.push_back('{who, exp_rd, exp_err, exp_lat});
      iss_q.push_back('{addr, wdata, rw});
      acc_cyc[who] = cyc;
      @(posedge clk);
      #1;
    end
    if (who) b_valid_i = 1'b0;
    else a_valid_i = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL done_timeout: %0d transactions pending, required 0", exp_q.size());
      exp_q.delete();
      iss_q.delete();
    end
  endtask

  task automatic drive_ret(input logic [15:0] a, input logic r, input logic [15:0] d);
    valid_i = 1'b1; addr_i = a; rw_i = r; rdata_i = d;
    @(negedge clk);
    valid_i = 1'b0; addr_i = 16'h0000; rw_i = 1'b0; rdata_i = 16'h0000;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Chain model: returns chain_lat cycles after the issue cycle
  initial begin
    logic [15:0] ra;
    logic        rr;
    valid_i = 1'b0; addr_i = 16'h0000; rw_i = 1'b0; rdata_i = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst_n && valid_o && chain_mode != M_NONE) begin
        ra = addr_o;
        rr = rw_o;
        repeat (chain_lat) @(negedge clk);
        case (chain_mode)
          M_BADADDR: begin
            drive_ret(ra ^ 16'h0001, rr, ~chain_ret);
            @(negedge clk);
            drive_ret(ra, rr, chain_ret);
          end
          M_BADRW: drive_ret(ra, ~rr, chain_ret);
          default: drive_ret(ra, rr, chain_ret);
        endcase
      end
    end
  end

  // Monitor: issue checks and scoreboard pop on done
  initial begin
    iss_t e_iss;
    exp_t e;
    logic w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (valid_o) begin
          chk("issue_one_cycle", 32'(valid_prev), 32'(0));
          if (iss_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL issue_unexpected: valid_o=1 addr 0x%0h, required no issue", addr_o);
          end else begin
            e_iss = iss_q.pop_front();
            chk("issue_addr", 32'(addr_o), 32'(e_iss.addr));
            chk("issue_wdata", 32'(wdata_o), 32'(e_iss.wdata));
            chk("issue_rw", 32'(rw_o), 32'(e_iss.rw));
            chk("issue_rdata_o", 32'(rdata_o), 32'(0));
          end
          iss_cyc = cyc;
        end
        valid_prev = valid_o;
        if ((a_err_o && !a_done_o) || (b_err_o && !b_done_o)) begin
          tests++;
          failed++;
          $display("FAIL err_without_done: a_err=%0d b_err=%0d, required done alongside", a_err_o, b_err_o);
        end
        if (a_done_o || b_done_o) begin
          done_cnt++;
          w = b_done_o;
          chk("done_exclusive", 32'(a_done_o & b_done_o), 32'(0));
          chk("no_issue_on_done", 32'(valid_o), 32'(0));
          if (exp_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL done_unexpected: a_done=%0d b_done=%0d, required none", a_done_o, b_done_o);
          end else begin
            e = exp_q.pop_front();
            chk("done_who", 32'(w), 32'(e.who));
            chk("done_rdata", 32'(w ? b_rdata_o : a_rdata_o), 32'(e.rdata));
            chk("done_err", 32'(w ? b_err_o : a_err_o), 32'(e.err));
            chk("done_latency", 32'(cyc - iss_cyc), 32'(e.lat));
            last_rd[e.who] = e.rdata;
            done_cyc[w] = cyc;
          end
        end
      end else begin
        valid_prev = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    vec_t vt[NV];
    int   dc;
    vt[0] = '{1'b0, 16'h0002, 16'h0000, 1'b0, 16'h03FF, 2, M_GOOD,    16'h03FF, 1'b0, 3};
    vt[1] = '{1'b1, 16'h0005, 16'h001F, 1'b1, 16'hBEEF, 1, M_GOOD,    16'h0000, 1'b0, 2};
    vt[2] = '{1'b0, 16'h1234, 16'h0000, 1'b0, 16'hA5A5, 1, M_GOOD,    16'hA5A5, 1'b0, 2};
    vt[3] = '{1'b0, 16'h0002, 16'h0000, 1'b0, 16'h0777, 1, M_BADADDR, 16'h0777, 1'b0, 4};
    vt[4] = '{1'b1, 16'h00F0, 16'h0000, 1'b0, 16'h1234, 1, M_NONE,    16'h0000, 1'b1, 5};
    vt[5] = '{1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1111, 4, M_GOOD,    16'h1111, 1'b0, 5};
    vt[6] = '{1'b0, 16'h0020, 16'h00AA, 1'b1, 16'h2222, 5, M_GOOD,    16'h0000, 1'b1, 5};
    vt[7] = '{1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'h5A5A, 3, M_GOOD,    16'h5A5A, 1'b0, 4};
    vt[8] = '{1'b1, 16'h0022, 16'h0000, 1'b0, 16'h3333, 1, M_BADRW,   16'h0000, 1'b1, 5};

    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    a_addr_i = 16'h0000; a_wdata_i = 16'h0000; a_rw_i = 1'b0;
    b_addr_i = 16'h0000; b_wdata_i = 16'h0000; b_rw_i = 1'b0;
    a_valid_i = 1'b1;
    b_valid_i = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", 32'({a_ready_o, b_ready_o, a_done_o, b_done_o, a_err_o, b_err_o, valid_o, rw_o}), 32'(0));
    chk("reset_data", 32'(a_rdata_o | b_rdata_o | addr_o | wdata_o | rdata_o), 32'(0));
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      chain_mode = vt[i].mode;
      chain_lat  = vt[i].lat;
      chain_ret  = vt[i].ret;
      req(vt[i].who, vt[i].addr, vt[i].wdata, vt[i].rw, vt[i].exp_rd, vt[i].exp_err, vt[i].exp_lat);
      wait_empty();
      repeat (2) @(negedge clk);
      chk("hold_a_rdata", 32'(a_rdata_o), 32'(last_rd[0]));
      chk("hold_b_rdata", 32'(b_rdata_o), 32'(last_rd[1]));
    end

    // Round-robin: B granted last, so A wins; B follows right after A's done
    chain_mode = M_GOOD; chain_lat = 1; chain_ret = 16'h4444;
    fork
      req(1'b0, 16'h0100, 16'h0000, 1'b0, 16'h4444, 1'b0, 2);
      req(1'b1, 16'h0200, 16'h0000, 1'b0, 16'h4444, 1'b0, 2);
      begin #2; chk("rr_pair1", 32'({a_ready_o, b_ready_o}), 32'(2)); end
    join
    wait_empty();
    chk("b_after_a_done", 32'(acc_cyc[1] - done_cyc[0]), 32'(1));
    @(negedge clk);
    fork
      req(1'b0, 16'h0101, 16'h0000, 1'b0, 16'h4444, 1'b0, 2);
      req(1'b1, 16'h0201, 16'h0000, 1'b0, 16'h4444, 1'b0, 2);
      begin #2; chk("rr_pair2", 32'({a_ready_o, b_ready_o}), 32'(2)); end
    join
    wait_empty();
    @(negedge clk);
    req(1'b0, 16'h0102, 16'h0000, 1'b0, 16'h4444, 1'b0, 2);
    wait_empty();
    @(negedge clk);
    fork
      req(1'b0, 16'h0103, 16'h0000, 1'b0, 16'h4444, 1'b0, 2);
      req(1'b1, 16'h0203, 16'h0000, 1'b0, 16'h4444, 1'b0, 2);
      begin #2; chk("rr_pair3", 32'({a_ready_o, b_ready_o}), 32'(1)); end
    join
    wait_empty();

    // Reset during WAIT; the late return must be ignored
    @(negedge clk);
    chain_mode = M_GOOD; chain_lat = 3; chain_ret = 16'h6666;
    req(1'b0, 16'h0300, 16'h0000, 1'b0, 16'h6666, 1'b0, 4);
    @(negedge clk);
    chk("rst_seq_issued", 32'(valid_o), 32'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", 32'({a_done_o, b_done_o, a_err_o, b_err_o, valid_o}), 32'(0));
    chk("rst_mid_rdata", 32'(a_rdata_o | b_rdata_o), 32'(0));
    exp_q.delete();
    iss_q.delete();
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    dc = done_cnt;
    repeat (6) @(negedge clk);
    chk("no_done_after_reset", 32'(done_cnt), 32'(dc));
    chk("idle_after_reset", 32'(valid_o), 32'(0));

    chain_lat = 1; chain_ret = 16'h7777;
    fork
      req(1'b0, 16'h0002, 16'h0000, 1'b0, 16'h7777, 1'b0, 2);
      req(1'b1, 16'h0004, 16'h0000, 1'b0, 16'h7777, 1'b0, 2);
      begin #2; chk("rr_after_reset", 32'({a_ready_o, b_ready_o}), 32'(2)); end
    join
    wait_empty();
    repeat (2) @(negedge clk);
    chk("post_reset_a_rdata", 32'(a_rdata_o), 32'(last_rd[0]));
    chk("post_reset_b_rdata", 32'(b_rdata_o), 32'(last_rd[1]));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
